// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave timer/input path.
package microwave_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_RUNNING = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam bcd_t BCD_NINE = 4'd9;
  localparam bcd_t BCD_FIVE = 4'd5;

  // Keypad codes above 9 are function keys and never enter the time value.
  function automatic logic is_bcd(input bcd_t d);
    return d <= BCD_NINE;
  endfunction

endpackage

// File: rtl/bcd_cook_timer_if.sv
// Key/command inputs and time/status outputs of the cook timer.
interface bcd_cook_timer_if;
  import microwave_pkg::*;

  logic key_valid;
  bcd_t digit;
  logic start;
  logic stop;
  logic tick;
  bcd_t min_tens;
  bcd_t min_ones;
  bcd_t sec_tens;
  bcd_t sec_ones;
  logic running;
  logic done;

  // Keypad/controller side drives commands and observes the time.
  modport master (
    output key_valid, digit, start, stop, tick,
    input  min_tens, min_ones, sec_tens, sec_ones, running, done
  );

  // Timer side.
  modport slave (
    input  key_valid, digit, start, stop, tick,
    output min_tens, min_ones, sec_tens, sec_ones, running, done
  );
endinterface

// File: rtl/bcd_digit_down.sv
// One BCD digit of the countdown: parallel load, or decrement with
// borrow into the next more significant digit.
module bcd_digit_down
  import microwave_pkg::*;
(
  input  logic clk,
  input  logic clear,
  input  logic load,
  input  bcd_t load_val,
  input  logic dec,
  input  bcd_t reload,
  output bcd_t q,
  output logic borrow_out
);

  // A digit at zero asked to decrement wraps to its reload value and borrows.
  assign borrow_out = (q == '0) && dec;

  // Load has priority; the top never asserts load and dec together.
  always_ff @(posedge clk) begin
    if (clear)           q <= '0;
    else if (load)       q <= load_val;
    else if (borrow_out) q <= reload;
    else if (dec)        q <= q - 4'd1;
  end

endmodule

// File: rtl/bcd_cook_timer.sv
// Cook-time entry register and 1 Hz MM:SS countdown engine.
module bcd_cook_timer
  import microwave_pkg::*;
#(
  parameter int TICK_DIV = 0
) (
  input logic             clk,
  input logic             clear,
  bcd_cook_timer_if.slave bus
);

  // Only the external tick is supported; a nonzero divider is reserved
  // and leaves the countdown frozen rather than guessing a rate.
  localparam bit EXT_TICK = (TICK_DIV == 0);

  // Digit index: 0 sec_ones, 1 sec_tens, 2 min_ones, 3 min_tens.
  logic [3:0][DIGIT_W-1:0] q;
  logic [3:0][DIGIT_W-1:0] load_val;
  logic [3:0]              dec;
  logic [3:0]              borrow;
  logic                    load;

  state_t state;
  logic   running_r;
  logic   done_r;

  logic tick_en, is_zero, is_one, cancel, go_entry, shift, dec_en;

  assign tick_en  = EXT_TICK ? bus.tick : 1'b0;
  assign is_zero  = (q == '0);
  assign is_one   = (q[3] == '0) && (q[2] == '0) && (q[1] == '0) && (q[0] == 4'd1);

  // stop beats everything; it cancels entry or a paused cook.
  assign cancel   = bus.stop && (state == ST_ENTRY || state == ST_PAUSED);
  // start from entry needs a nonzero time and drops a coincident key.
  assign go_entry = bus.start && !bus.stop && (state == ST_ENTRY) && !is_zero;
  assign shift    = (state == ST_IDLE || state == ST_ENTRY) && bus.key_valid &&
                    is_bcd(bus.digit) && !cancel && !go_entry;
  // Only a tick seen while already RUNNING counts, and stop suppresses it.
  assign dec_en   = (state == ST_RUNNING) && tick_en && !bus.stop;

  // Shift-in / zeroing mux and the borrow chain.
  always_comb begin
    load     = shift || cancel;
    load_val = cancel ? '0 : {q[2], q[1], q[0], bus.digit};
    dec      = {borrow[2:0], dec_en};
  end

  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_digit_down u_digit (
      .clk        (clk),
      .clear      (clear),
      .load       (load),
      .load_val   (load_val[i]),
      .dec        (dec[i]),
      .reload     ((i == 1) ? BCD_FIVE : BCD_NINE),
      .q          (q[i]),
      .borrow_out (borrow[i])
    );
  end

  // Mode FSM with registered running/done flags.
  always_ff @(posedge clk) begin
    if (clear) begin
      state     <= ST_IDLE;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      running_r <= 1'b0;
      done_r    <= 1'b0;
      case (state)
        ST_IDLE: if (shift) state <= ST_ENTRY;
        ST_ENTRY: begin
          if (cancel) state <= ST_IDLE;
          else if (go_entry) begin
            state     <= ST_RUNNING;
            running_r <= 1'b1;
          end
        end
        ST_RUNNING: begin
          if (bus.stop) state <= ST_PAUSED;
          else if (dec_en && is_one) begin
            state  <= ST_DONE;
            done_r <= 1'b1;
          end else running_r <= 1'b1;
        end
        ST_PAUSED: begin
          if (bus.stop) state <= ST_IDLE;
          else if (bus.start) begin
            state     <= ST_RUNNING;
            running_r <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.sec_ones = q[0];
  assign bus.sec_tens = q[1];
  assign bus.min_ones = q[2];
  assign bus.min_tens = q[3];
  assign bus.running  = running_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_bcd_cook_timer.sv
// Scoreboard bench for bcd_cook_timer: directed scenarios then random
// stimulus, checked against a decimal-arithmetic model of the timer.
module tb_bcd_cook_timer;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  bcd_cook_timer_if bus ();

  bcd_cook_timer #(.TICK_DIV(0)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] mt, mo, st, so;
    logic       run, dn;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: mode plus the displayed time as a decimal number MMSS.
  localparam int M_IDLE = 0, M_ENTRY = 1, M_RUN = 2, M_PAUSE = 3, M_DONE = 4;
  int m_mode = M_IDLE;
  int m_val  = 0;

  function automatic int dec_time(input int v);
    int mm, ss;
    mm = v / 100;
    ss = v % 100;
    if (ss > 0) ss = ss - 1;
    else begin
      mm = mm - 1;
      ss = 59;
    end
    return mm * 100 + ss;
  endfunction

  task automatic model(input bit c, kv, input int d, input bit s, p, t);
    if (c) begin
      m_mode = M_IDLE;
      m_val  = 0;
    end else begin
      case (m_mode)
        M_IDLE, M_ENTRY: begin
          if (p && m_mode == M_ENTRY) begin
            m_mode = M_IDLE;
            m_val  = 0;
          end else if (s && m_mode == M_ENTRY && m_val != 0) m_mode = M_RUN;
          else if (kv && d <= 9) begin
            m_val  = (m_val * 10 + d) % 10000;
            m_mode = M_ENTRY;
          end
        end
        M_RUN: begin
          if (p) m_mode = M_PAUSE;
          else if (t) begin
            m_val = dec_time(m_val);
            if (m_val == 0) m_mode = M_DONE;
          end
        end
        M_PAUSE: begin
          if (p) begin
            m_mode = M_IDLE;
            m_val  = 0;
          end else if (s) m_mode = M_RUN;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  endtask

  // Drive one cycle of inputs away from the sampling edge and queue the
  // outputs expected after that edge.
  task automatic step(input bit c, kv, input int d, input bit s, p, t);
    exp_t e;
    @(negedge clk);
    clear         = c;
    bus.key_valid = kv;
    bus.digit     = d[3:0];
    bus.start     = s;
    bus.stop      = p;
    bus.tick      = t;
    model(c, kv, d, s, p, t);
    e.mt  = 4'((m_val / 1000) % 10);
    e.mo  = 4'((m_val / 100) % 10);
    e.st  = 4'((m_val / 10) % 10);
    e.so  = 4'(m_val % 10);
    e.run = (m_mode == M_RUN);
    e.dn  = (m_mode == M_DONE);
    exp_q.push_back(e);
  endtask

  task automatic key(input int d);  step(0, 1, d, 0, 0, 0); endtask
  task automatic go();              step(0, 0, 0, 1, 0, 0); endtask
  task automatic halt();            step(0, 0, 0, 0, 1, 0); endtask
  task automatic tk();              step(0, 0, 0, 0, 0, 1); endtask
  task automatic rst();             step(1, 0, 0, 0, 0, 0); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: the DUT presents a fresh result every cycle after the edge.
  initial begin
    exp_t e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones, bus.running, bus.done};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL out check %0d at %0t: got %h%h:%h%h run=%b done=%b, want %h%h:%h%h run=%b done=%b",
                   checks, $time, a.mt, a.mo, a.st, a.so, a.run, a.dn,
                   e.mt, e.mo, e.st, e.so, e.run, e.dn);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    clear = 1'b0;
    bus.key_valid = 1'b0;
    bus.digit = '0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.tick = 1'b0;

    rst(); rst();

    // Reset mid-run at 00:42, then a tick must do nothing.
    key(4); key(2); go(); idle(1); rst(); tk(); idle(1);

    // 01:30 counting down two ticks.
    key(1); key(3); key(0); go(); idle(2); tk(); idle(1); tk(); idle(1);
    halt(); halt();

    // 00:01 to done, single done pulse then idle.
    key(0); key(1); go(); tk(); idle(3);

    // Borrow cases and an over-59 seconds field.
    key(1); key(0); key(0); go(); tk(); halt(); halt();
    key(1); key(0); key(0); key(0); go(); tk(); halt(); halt();
    key(7); key(5); go(); tk(); tk(); tk(); halt(); halt();

    // stop+tick pause, resume, cancel.
    key(2); key(1); key(0); go(); step(0, 0, 0, 0, 1, 1); go(); idle(1);
    halt(); halt(); idle(1);

    // Tick on the start cycle is not applied; start+key drops the key.
    key(3); step(0, 1, 5, 1, 0, 1); tk(); halt(); halt();

    // Ignored inputs, then five-digit entry.
    key(10); go(); key(0); go(); key(5); go(); key(3); key(4); halt(); halt();
    key(1); key(2); key(3); key(4); key(5); halt();

    // Run to completion from 00:03.
    key(3); go(); repeat (4) begin tk(); idle(1); end
    idle(2);

    // Random traffic, biased toward short times so runs complete.
    for (int i = 0; i < 4000; i++) begin
      bit c, kv, s, p, t;
      int d;
      c  = ($urandom_range(0, 199) == 0);
      kv = ($urandom_range(0, 99) < 25);
      d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      s  = ($urandom_range(0, 99) < 12);
      p  = ($urandom_range(0, 99) < 4);
      t  = ($urandom_range(0, 99) < 35);
      step(c, kv, d, s, p, t);
    end
    idle(2);

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expected results left, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_cook_timer.md
# bcd_cook_timer

- Cook-time register and countdown engine of the microwave's timer and input control path.
- Sits directly downstream of the keypad debounce stage built on the 0-to-7 non-recycling counter.
  - That stage emits one `key_valid` pulse per stable key press.
  - This block shifts the key digits into a four-digit MM:SS BCD value, then counts it down on a 1 Hz tick.
- Outputs drive the display decoder and the magnetron/lamp control FSM.

## Interface
Parameters:
- `TICK_DIV`, default 0: reserved; 0 means `tick` is supplied externally and used as-is.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `clear`  in  1  reset, synchronous, active-high; forces IDLE and zeroes all digits.
- `key_valid`  in  1  one-cycle pulse from the debounce stage: a new digit is present.
- `digit`  in  4  BCD key value; sampled only when `key_valid`=1.
- `start`  in  1  one-cycle pulse: begin or resume countdown.
- `stop`  in  1  one-cycle pulse: pause, or cancel when already paused/entering.
- `tick`  in  1  one-cycle 1 Hz enable pulse.
- `min_tens`, `min_ones`, `sec_tens`, `sec_ones`  out  4 each  current time, BCD.
- `running`  out  1  high while in RUNNING.
- `done`  out  1  one-cycle pulse when the countdown reaches 00:00.

## Operation
- States: IDLE, ENTRY, RUNNING, PAUSED, DONE.
- Reset (`clear`=1):
  - state=IDLE; all digits=0; `running`=0; `done`=0.
  - `clear` overrides every other input in the same cycle.
- IDLE/ENTRY, `key_valid` with `digit`<=9: left shift.
  - `min_tens`<=`min_ones`, `min_ones`<=`sec_tens`, `sec_tens`<=`sec_ones`, `sec_ones`<=`digit`; state=ENTRY.
  - The oldest digit falls off. Maximum entry is 99:99.
- `digit`>9: key ignored, no state change.
- Seconds field >59 is legal as entered (e.g. 01:75). It counts down through 75..00 before borrowing a minute. After any borrow, `sec_tens` reloads to 5.
- `start` in ENTRY:
  - digits nonzero: go to RUNNING.
  - digits all zero: ignored.
- `start` in IDLE is ignored.
- RUNNING, `tick`: decrement one second with BCD borrow chain `sec_ones`→`sec_tens`→`min_ones`→`min_tens`.
  - A digit at 0 with a borrow reloads to 9, or to 5 for `sec_tens`.
  - The decrement that yields 00:00 moves the block to DONE.
- DONE:
  - lasts exactly one cycle with `done`=1 and digits 00:00; then IDLE.
  - Inputs other than `clear` are ignored.
- `stop` by state:
  - RUNNING→PAUSED, digits held.
  - PAUSED or ENTRY→IDLE, digits zeroed.
  - IDLE: no effect.
- `start` in PAUSED→RUNNING.
- `key_valid` in RUNNING/PAUSED is ignored.
- Simultaneous events:
  - `stop`+`start`: `stop` wins.
  - `stop`+`tick` in RUNNING: `stop` wins, no decrement.
  - `start`+`key_valid` in ENTRY: `start` wins, key dropped.
  - `tick` on the cycle of entering RUNNING: not applied.

## Timing
- Every response is registered: inputs sampled at edge N, outputs valid after edge N.
- Digit shift visible one cycle after the `key_valid` edge.
- `running` rises one cycle after the accepted `start`; falls one cycle after `stop` or terminal tick.
- `done` is high for the single cycle following the tick that reached 00:00. It is never high twice per run.
- Pulse inputs held high for multiple cycles act once per cycle; upstream guarantees single-cycle pulses.
- Latency `start`→first decrement: first `tick` strictly after RUNNING is entered.

## Structure
- Shared package `microwave_pkg`:
  - state encoding constants: IDLE=0, ENTRY=1, RUNNING=2, PAUSED=3, DONE=4 (3 bits).
  - BCD constants `BCD_NINE`=9, `BCD_FIVE`=5.
  - digit width 4.
- Sub-module `bcd_digit_down`:
  - inputs: `clk`, `clear`, `load`, `load_val`, `dec`, reload value.
  - outputs: `q`, `borrow_out` (q==0 && dec).
  - Instantiated four times, `sec_tens` with reload 5.
- Top holds the FSM and the shift-in muxing.

## Test plan
- Reset mid-RUNNING at 00:42 → next cycle digits 00:00, `running`=0, state IDLE; subsequent `tick` has no effect.
- Keys 1,3,0 then `start`, 2 ticks → display 01:30, then 01:29, then 01:28; `running`=1 from the cycle after `start`.
- Enter 00:01, `start`, one `tick` → next cycle 00:00, `done`=1 for one cycle, then IDLE with `done`=0.
- Enter 01:00, `start`, `tick` → 00:59. Enter 10:00, `tick` → 09:59. Enter 00:75 → counts 75, 74, … without borrow.
- RUNNING at 02:10: `stop`+`tick` same cycle → PAUSED at 02:10; `start` → resumes 02:10; `stop`,`stop` → IDLE at 00:00.
- Digit 0xA, `start` with 00:00, and keys pressed while RUNNING → all ignored; five keys 1,2,3,4,5 → display 23:45.
